// File: rtl/hk_round_sequencer.sv
// hk_round_sequencer: drives the HK constant memory for the SHA-256 core.
// After reset it kicks off the ROM-to-RAM copy and waits for MEM_RDY.
// Per block it streams NUM_H initial hash words and then NUM_K round constants.
// Each word uses an ISSUE cycle (address on the port, data captured at its end)
// followed by a PRESENT phase that holds WORD_VALID until the consumer accepts.
module hk_round_sequencer #(
   parameter int NUM_H       = 8,
   parameter int NUM_K       = 64,
   parameter int RDY_TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        BLOCK_START,
   input  logic        MEM_RDY,
   input  logic [31:0] MEM_DR,
   output logic        COPY_ROM,
   output logic        HK_SELECTOR,
   output logic [2:0]  H_ADDR,
   output logic [5:0]  K_ADDR,
   output logic [31:0] WORD_DATA,
   output logic        WORD_IS_K,
   output logic [5:0]  WORD_IDX,
   output logic        WORD_VALID,
   input  logic        WORD_READY,
   output logic        BUSY,
   output logic        BLOCK_DONE,
   output logic        SEQ_READY,
   output logic        ERR
);

   localparam int CW = $clog2(RDY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_INIT, S_WAIT_RDY, S_READY, S_ISSUE, S_PRESENT, S_DONE, S_FAULT
   } state_t;

   state_t state_q, state_d;

   logic          copy_q, copy_d;
   logic          sel_q, sel_d;
   logic [2:0]    h_addr_q, h_addr_d;
   logic [5:0]    k_addr_q, k_addr_d;
   logic [31:0]   data_q, data_d;
   logic          is_k_q, is_k_d;
   logic [5:0]    idx_q, idx_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [CW:0]   cnt_inc;
   logic          timeout;
   logic          h_last, k_last;

   assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
   assign timeout = (cnt_inc == (CW+1)'(RDY_TIMEOUT));
   assign h_last  = (h_addr_q == 3'(NUM_H - 1));
   assign k_last  = (k_addr_q == 6'(NUM_K - 1));

   // State and registered outputs; synchronous reset back to INIT.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_INIT;
         copy_q   <= 1'b0;
         sel_q    <= 1'b0;
         h_addr_q <= '0;
         k_addr_q <= '0;
         data_q   <= '0;
         is_k_q   <= 1'b0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         copy_q   <= copy_d;
         sel_q    <= sel_d;
         h_addr_q <= h_addr_d;
         k_addr_q <= k_addr_d;
         data_q   <= data_d;
         is_k_q   <= is_k_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state decode; MEM_RDY takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:     state_d = S_WAIT_RDY;
         S_WAIT_RDY: if (MEM_RDY) state_d = S_READY;
                     else if (timeout) state_d = S_FAULT;
         S_READY:    if (BLOCK_START) state_d = S_ISSUE;
         S_ISSUE:    state_d = S_PRESENT;
         S_PRESENT:  if (WORD_READY) state_d = (sel_q && k_last) ? S_DONE : S_ISSUE;
         S_DONE:     state_d = S_READY;
         S_FAULT:    state_d = S_FAULT;
         default:    state_d = S_INIT;
      endcase
   end

   // Next values of the registered outputs, address counters and timeout counter.
   always_comb begin
      copy_d   = 1'b0;
      sel_d    = sel_q;
      h_addr_d = h_addr_q;
      k_addr_d = k_addr_q;
      data_d   = data_q;
      is_k_d   = is_k_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_INIT: begin
            copy_d = 1'b1;
            cnt_d  = '0;
         end
         S_WAIT_RDY: begin
            cnt_d = cnt_inc[CW-1:0];
            if (MEM_RDY)      cnt_d = '0;
            else if (timeout) err_d = 1'b1;
         end
         S_READY: begin
            if (BLOCK_START) begin
               busy_d   = 1'b1;
               sel_d    = 1'b0;
               h_addr_d = '0;
            end
         end
         S_ISSUE: begin
            // Memory data for the address held this cycle is captured here.
            data_d  = MEM_DR;
            valid_d = 1'b1;
            is_k_d  = sel_q;
            idx_d   = sel_q ? k_addr_q : {3'b000, h_addr_q};
         end
         S_PRESENT: begin
            if (WORD_READY) begin
               valid_d = 1'b0;
               if (!sel_q) begin
                  if (h_last) begin
                     h_addr_d = '0;
                     k_addr_d = '0;
                     sel_d    = 1'b1;
                  end else begin
                     h_addr_d = h_addr_q + 3'd1;
                  end
               end else if (k_last) begin
                  k_addr_d = '0;
                  sel_d    = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  k_addr_d = k_addr_q + 6'd1;
               end
            end
         end
         S_DONE:  busy_d = 1'b0;
         S_FAULT: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
         default: ;
      endcase
   end

   assign COPY_ROM    = copy_q;
   assign HK_SELECTOR = sel_q;
   assign H_ADDR      = h_addr_q;
   assign K_ADDR      = k_addr_q;
   assign WORD_DATA   = data_q;
   assign WORD_IS_K   = is_k_q;
   assign WORD_IDX    = idx_q;
   assign WORD_VALID  = valid_q;
   assign BUSY        = busy_q;
   assign BLOCK_DONE  = done_q;
   assign SEQ_READY   = (state_q == S_READY);
   assign ERR         = err_q;

endmodule
